// File: rtl/note_pkg.sv
// Shared constants, FSM encoding and index helper for the octave/note index encoder.
package note_pkg;

    localparam int unsigned NOTES_PER_OCTAVE = 12;
    localparam int unsigned MAX_OCTAVE       = 5;
    localparam int unsigned NOTE_GROUP_MAX   = 2;

    localparam int unsigned OCT_W      = 3;
    localparam int unsigned NOTE_W     = 4;
    localparam int unsigned ACC_W      = 7;
    localparam int unsigned NUM_W      = 6;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned CALC_STEPS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // octave*12 + note built from shifts, used only for the legality check
    function automatic logic [IDX_W-1:0] flat_index(input logic [OCT_W-1:0] oct,
                                                    input logic [NOTE_W-1:0] nt);
        return IDX_W'({oct, 3'b000}) + IDX_W'({oct, 2'b00}) + IDX_W'(nt);
    endfunction

endpackage

// File: rtl/note_index_encoder.sv
// Converts an octave/note pair to a flat note index with a 3-step shift-add datapath.
// Illegal pairs bypass the datapath and report err with a zero index.
module note_index_encoder
    import note_pkg::*;
#(
    parameter int unsigned MAX_INDEX = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OCT_W-1:0]  octave,
    input  logic [NOTE_W-1:0] note,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_W-1:0]  numerator,
    output logic              err
);

    state_t             r_state;
    state_t             w_next_state;
    logic [OCT_W-1:0]   r_octave;
    logic [OCT_W-1:0]   w_octave_d;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_d;
    logic [ACC_W-1:0]   w_addend;
    logic [ACC_W-1:0]   w_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_out_valid_d;
    logic               r_err;
    logic               w_err_d;
    logic [NUM_W-1:0]   r_num;
    logic [NUM_W-1:0]   w_num_d;
    logic               w_accept;
    logic               w_illegal;
    logic               w_calc_last;

    assign w_accept    = in_valid & r_in_ready;
    assign w_illegal   = (note[3:2] > 2'(NOTE_GROUP_MAX))
                       | (octave > OCT_W'(MAX_OCTAVE))
                       | (32'(flat_index(octave, note)) > MAX_INDEX);
    assign w_calc_last = (r_cnt == CNT_W'(CALC_STEPS - 1));

    // One octave bit per CALC cycle contributes 12 << bit position
    assign w_addend = ((r_cnt < CNT_W'(CALC_STEPS)) && r_octave[r_cnt])
                    ? (ACC_W'(NOTES_PER_OCTAVE) << r_cnt) : '0;
    assign w_sum    = r_acc + w_addend;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_next_state = w_illegal ? ST_HOLD : ST_CALC;
            ST_CALC: if (w_calc_last) w_next_state = ST_HOLD;
            ST_HOLD: if (out_ready)   w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // Next values for datapath and output registers
    always_comb begin
        w_octave_d    = r_octave;
        w_acc_d       = r_acc;
        w_cnt_d       = r_cnt;
        w_out_valid_d = r_out_valid;
        w_err_d       = r_err;
        w_num_d       = r_num;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_octave_d = octave;
                    if (w_illegal) begin
                        w_out_valid_d = 1'b1;
                        w_err_d       = 1'b1;
                        w_num_d       = '0;
                    end else begin
                        w_acc_d = ACC_W'(note);
                        w_cnt_d = '0;
                    end
                end
            end
            ST_CALC: begin
                w_acc_d = w_sum;
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_calc_last) begin
                    w_out_valid_d = 1'b1;
                    w_err_d       = 1'b0;
                    w_num_d       = w_sum[NUM_W-1:0];
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_err_d       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // in_ready is registered from the next state so it stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_octave    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_num       <= '0;
        end else begin
            r_octave    <= w_octave_d;
            r_acc       <= w_acc_d;
            r_cnt       <= w_cnt_d;
            r_in_ready  <= (w_next_state == ST_IDLE);
            r_out_valid <= w_out_valid_d;
            r_err       <= w_err_d;
            r_num       <= w_num_d;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign numerator = r_num;

endmodule
